// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Request/response bundle between the execute-stage control and the iterative
// RV32M multiply/divide unit.
//   start  : request, only taken while the unit is idle
//   funct3 : M-extension operation select
//   a, b   : rs1 / rs2 operands
//   busy   : unit holds an instruction (stall PC update and register write)
//   done   : one-cycle pulse, rslt valid
//   rslt   : registered result, held until the next accepted start
// Modports: master = requester side, slave = muldiv_unit side.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] rslt;

    modport master (
        output start, funct3, a, b,
        input  busy, done, rslt
    );

    modport slave (
        input  start, funct3, a, b,
        output busy, done, rslt
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit. One multiplier bit (shift-add, LSB
// first) or one quotient bit (restoring, MSB first) per cycle over XLEN
// cycles, with sign handling done on magnitudes and corrected at the end.
// Fixed latency of XLEN+1 cycles from accept to done, no early termination.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if.slave (start/funct3/a/b in, busy/done/rslt out)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]        state_r;
    logic [CW-1:0]     count_r;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   mop_r;       // multiplicand magnitude or divisor magnitude
    logic [2*XLEN-1:0] prod_r;      // {acc, multiplier} or {remainder, quotient}
    logic              neg_res_r;   // product / quotient must be negated
    logic              neg_rem_r;   // remainder must be negated (dividend negative)
    logic              dz_r;        // divisor was zero
    logic [XLEN-1:0]   rslt_r;

    logic              sa_s;
    logic              sb_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_shift_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_sub_s;
    logic [2*XLEN-1:0] prod_nxt_s;
    logic [2*XLEN-1:0] full_s;
    logic [XLEN-1:0]   result_s;

    // Magnitude of a value; only negates when the source is treated as signed.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] m;
        if (sgn && v[XLEN-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Operand signedness for the requested operation.
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        if (bus.funct3[2]) begin
            // DIV / REM signed, DIVU / REMU unsigned
            sa_s = ~bus.funct3[0];
            sb_s = ~bus.funct3[0];
        end else begin
            sa_s = (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
            sb_s = (bus.funct3[1:0] == 2'b01);
        end
    end

    // One shift-add or restoring-divide step on the working register.
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, mop_r};
        div_shift_s = prod_r[2*XLEN-1:XLEN-1];
        div_ge_s    = (div_shift_s >= {1'b0, mop_r});
        // True difference is below the divisor, so XLEN bits are enough.
        div_sub_s   = div_shift_s[XLEN-1:0] - mop_r;
        prod_nxt_s  = prod_r;
        if (op_r[2]) begin
            if (div_ge_s) begin
                prod_nxt_s = {div_sub_s, prod_r[XLEN-2:0], 1'b1};
            end else begin
                prod_nxt_s = {div_shift_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b0};
            end
        end else begin
            if (prod_r[0]) begin
                prod_nxt_s = {mul_sum_s, prod_r[XLEN-1:1]};
            end else begin
                prod_nxt_s = {1'b0, prod_r[2*XLEN-1:1]};
            end
        end
    end

    // Sign correction and result selection from the final step's value.
    always_comb begin
        if (neg_res_r) begin
            full_s = -prod_nxt_s;
        end else begin
            full_s = prod_nxt_s;
        end
        case (op_r)
            3'b000: result_s = full_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011: result_s = full_s[2*XLEN-1:XLEN];
            3'b100,
            3'b101: begin
                // Divide by zero leaves an all-ones quotient regardless of sign.
                if (dz_r) begin
                    result_s = {XLEN{1'b1}};
                end else if (neg_res_r) begin
                    result_s = -prod_nxt_s[XLEN-1:0];
                end else begin
                    result_s = prod_nxt_s[XLEN-1:0];
                end
            end
            3'b110,
            3'b111: begin
                if (neg_rem_r) begin
                    result_s = -prod_nxt_s[2*XLEN-1:XLEN];
                end else begin
                    result_s = prod_nxt_s[2*XLEN-1:XLEN];
                end
            end
            default: result_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM, operand latching, iteration and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            count_r   <= {CW{1'b0}};
            op_r      <= 3'b000;
            mop_r     <= {XLEN{1'b0}};
            prod_r    <= {(2*XLEN){1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            rslt_r    <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r   <= BUSY;
                        count_r   <= {CW{1'b0}};
                        op_r      <= bus.funct3;
                        neg_res_r <= (sa_s & bus.a[XLEN-1]) ^ (sb_s & bus.b[XLEN-1]);
                        neg_rem_r <= sa_s & bus.a[XLEN-1];
                        dz_r      <= (bus.b == {XLEN{1'b0}});
                        if (bus.funct3[2]) begin
                            mop_r  <= mag(bus.b, sb_s);
                            prod_r <= {{XLEN{1'b0}}, mag(bus.a, sa_s)};
                        end else begin
                            mop_r  <= mag(bus.a, sa_s);
                            prod_r <= {{XLEN{1'b0}}, mag(bus.b, sb_s)};
                        end
                    end
                end
                BUSY: begin
                    prod_r  <= prod_nxt_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == LAST) begin
                        state_r <= DONE;
                        rslt_r  <= result_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state_r == BUSY) || (state_r == DONE);
    assign bus.done = (state_r == DONE);
    assign bus.rslt = rslt_r;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int fails  = 0;

    // Architectural RV32M result from plain arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pa, pb, p;
        logic [31:0] r;
        r = 32'h0;
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'd1: begin pa = {{32{a[31]}}, a}; pb = {{32{b[31]}}, b}; p = pa * pb; r = p[63:32]; end
            3'd2: begin pa = {{32{a[31]}}, a}; pb = {32'h0, b}; p = pa * pb; r = p[63:32]; end
            3'd3: begin pa = {32'h0, a}; pb = {32'h0, b}; p = pa * pb; r = p[63:32]; end
            3'd4: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model: phase 0 idle, 1..33 counts cycles since accept, done in 33.
    int          phase;
    logic [31:0] pend;
    logic [31:0] exp_rslt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 0;
            exp_rslt <= 32'h0;
            pend     <= 32'h0;
        end else if (phase == 0) begin
            if (bus.start === 1'b1) begin
                pend  <= ref_op(bus.funct3, bus.a, bus.b);
                phase <= 1;
            end
        end else if (phase == 33) begin
            phase <= 0;
        end else begin
            if (phase == 32) exp_rslt <= pend;
            phase <= phase + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check1("busy", bus.busy, phase != 0);
            check1("done", bus.done, phase == 33);
            check32("rslt", bus.rslt, exp_rslt);
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // mode 0: quiet bus, 1: start pulses at cycles 5 and 20 plus operand churn,
    // 2: fully random bus activity while busy and start held into done.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int mode);
        int n;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = a;
        bus.b      = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (mode >= 1) begin
                bus.a      = $urandom;
                bus.b      = $urandom;
                bus.funct3 = 3'($urandom_range(0, 7));
            end
            if (mode == 1) bus.start = (n == 4 || n == 19);
            else if (mode == 2) bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        check32({name, "_latency"}, n + 1, 33);
        check32(name, bus.rslt, exp);
        bus.start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int dones;
        logic [2:0]  f;
        logic [31:0] a, b;
        bus.start = 1'b0; bus.funct3 = 3'b000; bus.a = 32'h0; bus.b = 32'h0;

        vecs.push_back('{"mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{"mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{"mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{"div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
        vecs.push_back('{"rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{"divu_big_2",  3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC});
        vecs.push_back('{"divu_z",      3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{"remu_z",      3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234});
        vecs.push_back('{"div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{"rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{"div_neg_z",   3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{"rem_neg_z",   3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB});
        vecs.push_back('{"div_m100_7",  3'd4, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2});

        // Pin the reference model to hand-computed values.
        check32("model_mul", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        foreach (vecs[i]) check32({"model_", vecs[i].name}, ref_op(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].exp);

        repeat (3) @(negedge clk);
        check1("reset_busy", bus.busy, 1'b0);
        check1("reset_done", bus.done, 1'b0);
        check32("reset_rslt", bus.rslt, 32'h0);
        rst_n = 1'b1;

        // MUL then reset after done.
        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        @(negedge clk);
        check1("busy_after_done", bus.busy, 1'b0);
        #2 rst_n = 1'b0;
        #1 check32("rslt_after_reset", bus.rslt, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Directed boundary cases back to back.
        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        // Start pulses and operand churn during a MUL.
        run_op("mul_ignore_start", 3'd0, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1);

        // Reset in the middle of a DIV.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 begin
            check1("midrst_busy", bus.busy, 1'b0);
            check1("midrst_done", bus.done, 1'b0);
            check32("midrst_rslt", bus.rslt, 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check32("midrst_no_done", dones, 0);
        run_op("div_after_rst", 3'd4, 32'd100, 32'd7, 32'd14, 0);

        // Randomized operations with a noisy bus.
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op("rand_op", f, a, b, ref_op(f, a, b), 2);
        end
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit on the execute path of the RV32I core, next to the ALU. It takes the same register-file operands as the ALU. It returns a 32-bit result that the write-back mux selects in place of the ALU result for M-extension instructions. It holds the instruction for 33 cycles while the control unit stalls PC update and register write on `busy`.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals `XLEN`.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  XLEN  rs1 operand (multiplicand / dividend)
- `b`  in  XLEN  rs2 operand (multiplier / divisor)
- `busy`  out  1  high in BUSY and DONE
- `done`  out  1  one-cycle pulse, `rslt` valid
- `rslt`  out  XLEN  registered result; held until next accepted `start`

## Operation
- **States:**
  - IDLE: `start`=1 latches `funct3`, `a`, `b` and moves to BUSY with count=0.
  - BUSY: performs one iteration per cycle. At count=XLEN-1 it moves to DONE.
  - DONE: writes `rslt`, asserts `done`, then moves to IDLE unconditionally.
- Operands are latched at acceptance. Later changes on `a`, `b`, `funct3` have no effect.
- **Sign handling:** for signed sources, take the magnitude (two's-complement negate if MSB set), compute unsigned, then fix the sign in DONE.
  - MULH: both signed.
  - MULHSU: `a` signed, `b` unsigned.
  - DIV/REM: both signed.
- **Multiply:** shift-add over a 2·XLEN product register, one multiplier bit per iteration, LSB first.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits of the sign-corrected 2·XLEN product.
- **Divide:** restoring, one quotient bit per iteration, MSB first, XLEN-bit remainder with an extra borrow bit.
  - Quotient is negated when the operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- **Divide by zero:** quotient = all ones (DIV and DIVU); remainder = `a` (REM and REMU).
- **Signed overflow:** `a`=0x80000000, `b`=0xFFFFFFFF for DIV gives quotient 0x80000000; for REM gives remainder 0.
- **Latency:** special cases take the same latency as normal ops. There is no early termination.
- **`start` outside IDLE:** ignored, with no queueing. `start` held high through DONE is not accepted until the cycle after `done`.

## Timing
- **Reset (async assert, sync release):** state IDLE, `busy`=0, `done`=0, `rslt`=0, internal registers 0. Reset mid-operation aborts silently with no `done`.
- **Accept and latency:** `start` sampled high at edge k in IDLE.
  - `busy`=1 from after edge k through edge k+33.
  - BUSY covers edges k+1..k+32.
  - `done`=1 and the new `rslt` are valid for exactly the cycle after edge k+32; return to IDLE at edge k+33.
  - Latency is 33 cycles from accept to `done`.
- **Back-to-back:** the earliest next accept is edge k+34 (the first cycle in IDLE), so throughput is one op per 34 cycles.
- **Outputs:** `busy` and `done` decode directly from state flops. `rslt` is a flop with no combinational path from inputs.
- **Widths:** all intermediate negation is mod 2^XLEN, and |0x80000000| = 0x80000000 as unsigned.

## Test plan
- **MUL, then reset:**
  - MUL `a`=7, `b`=0xFFFFFFFD → `done` 33 cycles after accept, `rslt`=0xFFFFFFEB, `busy` drops the cycle after `done`.
  - `rst_n` low after `done` → `rslt`=0.
- **High-half multiplies:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- **Signed divide:** DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- **Divide by zero:** DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. Signed overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. All at the same 33-cycle latency.
- **Start while busy:** pulse `start` with new operands at cycles 5 and 20 of a MUL → ignored; exactly one `done` with the original result. Operand bus changing during BUSY has no effect on `rslt`.
- **Reset mid-operation:** `rst_n` low at cycle 10 of a DIV → `busy`=0 and `done`=0 immediately with no later `done`; `rslt`=0. A fresh op after release completes normally.
